// File: rtl/event_word_packer.sv
// Packs a byte stream into 32-bit words, first byte in the top lane, and
// closes each event (maximal run of valid bytes) with a tagged trailer word.
module event_word_packer #(
    parameter logic [7:0] TRAILER_TAG = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        dout_last,
    output logic        sat_err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ID_W   = 8;

    // S_TRAIL means "padded word already sent, trailer goes out at the next edge".
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_TRAIL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [ID_W-1:0]     evt_id_q, evt_id_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                dout_last_q, dout_last_d;
    logic                sat_err_q, sat_err_d;

    logic [WORD_W-1:0]   trailer_c;
    logic [WORD_W-1:0]   lane_word_c;

    // Writing lane 0 starts a new word, so the other lanes are cleared there.
    function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                   input logic [1:0] idx,
                                                   input logic [7:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        case (idx)
            2'd0:    r = {b, 24'h000000};
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    assign trailer_c   = {TRAILER_TAG, evt_id_q, byte_cnt_q};
    assign lane_word_c = put_lane(acc_q, bidx_q, din);

    always_comb begin
        state_d      = state_q;
        bidx_d       = bidx_q;
        acc_d        = acc_q;
        byte_cnt_d   = byte_cnt_q;
        evt_id_d     = evt_id_q;
        sat_err_d    = sat_err_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    acc_d      = {din, 24'h000000};
                    bidx_d     = 2'd1;
                    byte_cnt_d = 16'd1;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                if (din_valid) begin
                    acc_d  = lane_word_c;
                    bidx_d = bidx_q + 2'd1;
                    if (byte_cnt_q == 16'hFFFF) begin
                        sat_err_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                    if (bidx_q == 2'd3) begin
                        dout_d       = lane_word_c;
                        dout_valid_d = 1'b1;
                    end
                end else if (bidx_q != 2'd0) begin
                    dout_d       = acc_q;
                    dout_valid_d = 1'b1;
                    state_d      = S_TRAIL;
                end else begin
                    dout_d       = trailer_c;
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b1;
                    evt_id_d     = evt_id_q + 8'd1;
                    state_d      = S_IDLE;
                end
            end
            S_TRAIL: begin
                // Trailer uses the old count; a new byte here opens the next event.
                dout_d       = trailer_c;
                dout_valid_d = 1'b1;
                dout_last_d  = 1'b1;
                evt_id_d     = evt_id_q + 8'd1;
                if (din_valid) begin
                    acc_d      = {din, 24'h000000};
                    bidx_d     = 2'd1;
                    byte_cnt_d = 16'd1;
                    state_d    = S_ACC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bidx_q       <= 2'd0;
            acc_q        <= '0;
            byte_cnt_q   <= '0;
            evt_id_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            sat_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bidx_q       <= bidx_d;
            acc_q        <= acc_d;
            byte_cnt_q   <= byte_cnt_d;
            evt_id_q     <= evt_id_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            sat_err_q    <= sat_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign sat_err    = sat_err_q;

endmodule

// File: tb/tb_event_word_packer.sv
// Bench for event_word_packer: queue-based event model compared every cycle,
// plus literal word sequences for the directed scenarios.
module tb_event_word_packer;

    localparam logic [7:0] TAG = 8'hEE;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        sat_err;

    event_word_packer #(.TRAILER_TAG(TAG)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .sat_err    (sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Emitted words as {last, word}
    logic [32:0] dut_log[$];
    logic [32:0] model_log[$];

    // Model state: the current event as plain counts and a byte queue
    int          m_cnt;
    bit          m_in_evt;
    logic [7:0]  m_wb[$];
    bit          m_pend;
    logic [31:0] m_pend_word;
    logic [7:0]  m_evt;
    logic        m_sat;
    logic [31:0] exp_dout;
    logic        exp_v;
    logic        exp_l;

    function automatic void model_reset();
        m_cnt = 0; m_in_evt = 0; m_wb.delete(); m_pend = 0; m_pend_word = '0;
        m_evt = 8'h00; m_sat = 1'b0;
        exp_dout = '0; exp_v = 1'b0; exp_l = 1'b0;
    endfunction

    function automatic void emit(input logic [31:0] w, input logic last, input bit already);
        if (already) begin
            n_total++;
            $display("FAIL model_collision: second word %h in one cycle, required none", w);
        end
        exp_dout = w; exp_v = 1'b1; exp_l = last;
        model_log.push_back({last, w});
    endfunction

    function automatic logic [31:0] pack_bytes();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_wb.size(); i++) w[31 - 8*i -: 8] = m_wb[i];
        return w;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b);
        bit          out_now;
        logic [31:0] tw;
        out_now = 0;
        exp_v = 1'b0; exp_l = 1'b0;
        if (m_pend) begin
            emit(m_pend_word, 1'b1, 0);
            m_pend = 0; out_now = 1;
        end
        if (v) begin
            if (!m_in_evt) begin
                m_in_evt = 1; m_cnt = 0; m_wb.delete();
            end
            m_cnt++;
            if (m_cnt > 65535) m_sat = 1'b1;
            m_wb.push_back(b);
            if (m_wb.size() == 4) begin
                emit(pack_bytes(), 1'b0, out_now);
                m_wb.delete();
            end
        end else if (m_in_evt) begin
            m_in_evt = 0;
            tw = {TAG, m_evt, 16'((m_cnt > 65535) ? 65535 : m_cnt)};
            m_evt = m_evt + 8'd1;
            if (m_wb.size() > 0) begin
                emit(pack_bytes(), 1'b0, out_now);
                m_pend = 1; m_pend_word = tw;
                m_wb.delete();
            end else begin
                emit(tw, 1'b1, out_now);
            end
        end
    endfunction

    // Single per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        n_total++;
        if (dout_valid === exp_v && dout_last === exp_l && dout === exp_dout && sat_err === m_sat) begin
            n_pass++;
        end else begin
            $display("FAIL cycle_cmp @%0t: got v=%b l=%b d=%h sat=%b, required v=%b l=%b d=%h sat=%b",
                     $time, dout_valid, dout_last, dout, sat_err, exp_v, exp_l, exp_dout, m_sat);
        end
        if (dout_valid === 1'b1) dut_log.push_back({dout_last, dout});
    end

    task automatic step(input logic v, input logic [7:0] b);
        din = b; din_valid = v;
        @(posedge clk);
        if (!rst) model_step(v, b);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; din = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_logs();
        dut_log.delete(); model_log.delete();
    endtask

    task automatic check_entry(input string name, input int idx, input logic [32:0] want);
        logic [32:0] d, m;
        d = 'x; m = 'x;
        if (idx >= 0 && idx < dut_log.size()) d = dut_log[idx];
        if (idx >= 0 && idx < model_log.size()) m = model_log[idx];
        n_total++;
        if (d === want && m === want) n_pass++;
        else $display("FAIL %s: entry %0d dut=%h model=%h, required %h", name, idx, d, m, want);
    endtask

    task automatic check_count(input string name, input int want);
        n_total++;
        if (dut_log.size() == want && model_log.size() == want) n_pass++;
        else $display("FAIL %s: dut words=%0d model words=%0d, required %0d",
                      name, dut_log.size(), model_log.size(), want);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b, required %b", name, got, want);
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; din_valid = 1'b0;
        model_reset();
        do_reset();

        // Full word then partial word with a 1-cycle gap
        clear_logs();
        step(1, 8'hA1); step(1, 8'hB2); step(1, 8'hC3); step(1, 8'hD4);
        step(0, 8'h00);
        step(1, 8'hE5); step(1, 8'hF6);
        idle(3);
        check_count("full_partial_count", 4);
        check_entry("full_word", 0, {1'b0, 32'hA1B2C3D4});
        check_entry("full_trailer", 1, {1'b1, 32'hEE000004});
        check_entry("partial_word", 2, {1'b0, 32'hE5F60000});
        check_entry("partial_trailer", 3, {1'b1, 32'hEE010002});

        // Back-to-back events with a single low cycle between them
        do_reset();
        clear_logs();
        step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44); step(1, 8'h55);
        step(0, 8'h00);
        step(1, 8'h66);
        idle(3);
        check_count("b2b_count", 5);
        check_entry("b2b_w0", 0, {1'b0, 32'h11223344});
        check_entry("b2b_w1", 1, {1'b0, 32'h55000000});
        check_entry("b2b_t0", 2, {1'b1, 32'hEE000005});
        check_entry("b2b_w2", 3, {1'b0, 32'h66000000});
        check_entry("b2b_t1", 4, {1'b1, 32'hEE010001});

        // Event-id wrap: 257 one-byte events, each next byte overlapping a trailer
        do_reset();
        clear_logs();
        repeat (257) begin
            step(1, 8'h5A);
            step(0, 8'h00);
        end
        idle(3);
        check_count("wrap_count", 514);
        check_entry("wrap_pad", 0, {1'b0, 32'h5A000000});
        check_entry("wrap_t256", 511, {1'b1, 32'hEEFF0001});
        check_entry("wrap_t257", 513, {1'b1, 32'hEE000001});

        // Saturation: 65540 bytes in one event (evt_id is 1 after the wrap run)
        clear_logs();
        repeat (65540) step(1, 8'($urandom));
        step(0, 8'h00);
        idle(2);
        check_count("sat_count", 16386);
        check_entry("sat_trailer", 16385, {1'b1, 32'hEE01FFFF});
        check_bit("sat_err_set", sat_err, 1'b1);
        clear_logs();
        step(1, 8'h01); idle(3);
        check_entry("post_sat_trailer", 1, {1'b1, 32'hEE020001});
        check_bit("sat_err_sticky", sat_err, 1'b1);

        // Reset two bytes into an event: outputs clear at once, no trailer follows
        step(1, 8'hC1); step(1, 8'hC2);
        rst = 1'b1;
        model_reset();
        #1;
        check_bit("rst_dout_zero", (dout == 32'h0), 1'b1);
        check_bit("rst_valid", dout_valid, 1'b0);
        check_bit("rst_sat", sat_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        idle(3);
        check_count("rst_no_trailer", 0);
        step(1, 8'h77); idle(3);
        check_entry("rst_next_word", 0, {1'b0, 32'h77000000});
        check_entry("rst_next_trailer", 1, {1'b1, 32'hEE000001});

        // Randomized traffic with varied gaps, checked cycle by cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom));
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/event_word_packer.md
# event_word_packer

Downstream stage of the byte serializer. Consumes the serializer's 8-bit `dout`/`dout_valid` stream, where each maximal run of consecutive valid bytes is one event. Packs each event into 32-bit words, first byte most significant, and closes every event with a tagged trailer word. Output feeds the 32-bit readout FIFO.

## Interface
- `TRAILER_TAG`, default 8'hEE: tag byte placed in bits [31:24] of every trailer word.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `din`  in  8: byte from the serializer.
- `din_valid`  in  1: `din` is valid this cycle. A low cycle ends the current event.
- `dout`  out  32: packed data word or trailer word.
- `dout_valid`  out  1: one-cycle strobe; `dout` is valid.
- `dout_last`  out  1: high together with `dout_valid` only on a trailer word.
- `sat_err`  out  1: sticky flag; set when any event's byte count saturates. Cleared only by `rst`.

## Operation
- **Byte packing**
  - A 2-bit byte index `bidx` selects the lane for each accepted byte: lane 0 = [31:24], lane 1 = [23:16], lane 2 = [15:8], lane 3 = [7:0].
  - Each accepted byte is written into the accumulator word at its lane.
  - When `bidx`=3 is accepted, the full word is registered to `dout` and `bidx` wraps to 0.
- **State machine**
  - IDLE: `din_valid`=1 → accept byte, set byte count to 1, go to ACC.
  - ACC: `din_valid`=1 → accept byte, increment byte count. `din_valid`=0 → go to FLUSH if `bidx`≠0, otherwise emit trailer and go to IDLE.
  - FLUSH: emit the partial word with unfilled lanes forced to 8'h00. Next cycle emits the trailer (TRAIL).
  - TRAIL: emit trailer, increment `evt_id`, return to IDLE.
  - A byte arriving with `din_valid`=1 while in FLUSH or TRAIL starts a new event: accept it into a fresh accumulator at lane 0.
- **Trailer word**: {TRAILER_TAG, `evt_id`[7:0], `byte_cnt`[15:0]}.
  - `evt_id` starts at 0 after reset and wraps 8'hFF→8'h00.
  - `byte_cnt` saturates at 16'hFFFF; saturation sets `sat_err`.
- **Zero-byte events do not exist.** No trailer is emitted without at least one accepted byte.
- **Accumulator clearing**: unused lanes are zeroed at the start of each word. Stale bytes never leak into a padded word.

## Timing
- **Reset values**: `dout`=32'h0, `dout_valid`=0, `dout_last`=0, `sat_err`=0. State is IDLE, `bidx`=0, byte count 0, `evt_id`=0.
- **Full-word latency**: a word whose 4th byte is sampled at edge n is presented after edge n, valid for exactly one cycle.
- **End of event**: the first low `din_valid` is sampled at edge m.
  - Partial word pending: padded word after edge m, trailer after edge m+1.
  - No partial word pending: trailer after edge m.
- **No output collisions**: a new event may start at edge m+1 or later, even with a 1-cycle gap. Its first full word cannot appear before edge m+4, so flush and trailer outputs never collide with data words.
- **Output behaviour**: `dout_valid` is never high on two words in the same cycle. Between strobes, `dout` holds its last value.
- **No backpressure**: no stall input exists; the downstream FIFO must accept 1 word/cycle.
- **Reset mid-event**: the partial word and pending trailer are discarded and outputs return to reset values immediately. Nothing from the aborted event is emitted after `rst` deasserts.

## Test plan
- **Full word**: A1,B2,C3,D4 on 4 consecutive cycles, then `din_valid`=0.
  - Required: 32'hA1B2C3D4 one cycle after D4.
  - Next cycle: 32'hEE000004 with `dout_last`=1.
- **Partial word with 1-cycle gap**: E5,F6 then `din_valid`=0 (second event after the first test).
  - Required: 32'hE5F60000, then 32'hEE010002 with `dout_last`=1.
- **Back-to-back events**: 11,22,33,44,55, one low cycle, then 66.
  - Required: 11223344, 55000000, EE000005.
  - Then after the second event ends: 66000000, EE010001. No dropped or merged bytes.
- **Event-id wrap**: 256 one-byte events of 8'h5A.
  - Required: the 256th trailer is 32'hEEFF0001, and the next trailer is 32'hEE000001.
- **Saturation**: one event of 65540 bytes.
  - Required: trailer count field = 16'hFFFF and `sat_err`=1.
  - `sat_err` stays set through subsequent events until `rst`.
- **Reset mid-event**: assert `rst` after 2 bytes of an event.
  - Required: outputs return to 0 immediately, no trailer appears.
  - The next event's trailer carries `evt_id` 0.
